control_multiciclo: RTL

- Multicycle main controller for the 19-bit processor.
- Sequences instruction fetch, decode, execute, memory access and writeback over a shared ALU and a single memory port.
- Drives ImmSrc of the immediate extend unit, plus all datapath enables and muxes.
- Stalls on a memory ready handshake and halts on the halt instruction.

---
 rtl/control_multiciclo_if.sv | 29 ++
 rtl/control_multiciclo.sv | 104 ++++++++++
 2 files changed

// File: rtl/control_multiciclo_if.sv
// control_multiciclo_if: controller <-> datapath signal bundle for the multicycle 19-bit core
interface control_multiciclo_if #(parameter int CNT_W = 16);
  logic [18:0] Instr;
  logic Zero;
  logic MemReady;
  logic MemReq;
  logic MemWrite;
  logic AdrSrc;
  logic IRWrite;
  logic PCWrite;
  logic RegWrite;
  logic ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUControl;
  logic [1:0] ResultSrc;
  logic [1:0] ImmSrc;
  logic Halted;
  logic [CNT_W-1:0] RetireCount;
  modport master(
    input Instr, Zero, MemReady,
    output MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
      ALUControl, ResultSrc, ImmSrc, Halted, RetireCount
  );
  modport slave(
    output Instr, Zero, MemReady,
    input MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA, ALUSrcB,
      ALUControl, ResultSrc, ImmSrc, Halted, RetireCount
  );
endinterface

// File: rtl/control_multiciclo.sv
// control_multiciclo: multicycle main controller sequencing fetch/decode/execute/memory/writeback
module control_multiciclo #(parameter int CNT_W = 16) (
  input logic clk,
  input logic rst_n,
  control_multiciclo_if.master bus
);
  typedef enum logic [3:0] {
    START, FETCH, DECODE, EXECR, EXECI, MEMADR, MEMRD, MEMWR, ALUWB, MEMWB, BRANCH, HALT
  } state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic retire;
  logic [1:0] op, funct;
  assign op = bus.Instr[18:17];
  assign funct = bus.Instr[16:15];
  assign bus.RetireCount = cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= START;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (retire && !(&cnt)) cnt <= cnt + 1'b1;
    end
  always_comb begin
    state_n = state;
    bus.MemReq = 1'b0;
    bus.MemWrite = 1'b0;
    bus.AdrSrc = 1'b0;
    bus.IRWrite = 1'b0;
    bus.PCWrite = 1'b0;
    bus.RegWrite = 1'b0;
    bus.ALUSrcA = 1'b0;
    bus.ALUSrcB = 2'b00;
    bus.ALUControl = 2'b00;
    bus.ResultSrc = 2'b00;
    bus.Halted = 1'b0;
    case (state)
      START: state_n = FETCH;
      FETCH: begin
        bus.MemReq = 1'b1;
        bus.ALUSrcB = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
        state_n = bus.MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        bus.ALUSrcB = 2'b01;
        state_n = op == 2'b00 ? EXECR : op == 2'b01 ? EXECI : op == 2'b10 ? MEMADR :
                  funct == 2'b11 ? HALT : BRANCH;
      end
      EXECR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUControl = funct;
        state_n = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.ALUControl = funct;
        state_n = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        state_n = FETCH;
      end
      MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b01;
        state_n = funct[0] ? MEMWR : MEMRD;
      end
      MEMRD: begin
        bus.MemReq = 1'b1;
        bus.AdrSrc = 1'b1;
        state_n = bus.MemReady ? MEMWB : MEMRD;
      end
      MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.ResultSrc = 2'b01;
        state_n = FETCH;
      end
      MEMWR: begin
        bus.MemReq = 1'b1;
        bus.MemWrite = 1'b1;
        bus.AdrSrc = 1'b1;
        state_n = bus.MemReady ? FETCH : MEMWR;
      end
      BRANCH: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUControl = 2'b01;
        bus.PCWrite = funct == 2'b00 || (funct == 2'b01 && bus.Zero) || (funct == 2'b10 && !bus.Zero);
        state_n = FETCH;
      end
      HALT: bus.Halted = 1'b1;
      default: state_n = START;
    endcase
  end
  // the halt instruction counts as retired on its DECODE -> HALT transition
  assign retire = state == ALUWB || state == MEMWB || state == BRANCH ||
                  (state == MEMWR && bus.MemReady) ||
                  (state == DECODE && op == 2'b11 && funct == 2'b11);
  assign bus.ImmSrc = (state == START || state == FETCH || state == HALT) ? 2'b00 : op;
endmodule
